// File: rtl/pixel_enhance_pipe.sv
// pixel_enhance_pipe: two-stage valid/ready RGB enhancer (bypass/brighten/darken/invert)
// with per-frame config latching, optional face tint and per-frame pixel statistics.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   s_pixel/s_valid/s_ready           input stream, packed {R,G,B}
//   s_sof, s_face                     start-of-frame and face-region flags for the input beat
//   mode, shift                       enhancement config, latched on accepted SOF beats
//   m_pixel/m_valid/m_ready, m_sof    output stream and aligned start-of-frame
//   frame_count, last_frame_pixels    frames seen since reset, size of last completed frame
//
// Optional feature: define PIXEL_ENH_FACE_TINT_EN to enable the face tint
// (R forced to max, G and B halved) on pixels flagged with s_face.

module pixel_enhance_pipe #(
    parameter int R_W     = 5,
    parameter int G_W     = 6,
    parameter int B_W     = 5,
    parameter int SHIFT_W = 3,
    localparam int PIX_W  = R_W + G_W + B_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   s_pixel,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_sof,
    input  logic               s_face,
    input  logic [1:0]         mode,
    input  logic [SHIFT_W-1:0] shift,
    output logic [PIX_W-1:0]   m_pixel,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_sof,
    output logic [15:0]        frame_count,
    output logic [23:0]        last_frame_pixels
);

    localparam int MW = (R_W > G_W) ? ((R_W > B_W) ? R_W : B_W)
                                    : ((G_W > B_W) ? G_W : B_W);

    localparam logic [MW-1:0] R_MAX = MW'((64'd1 << R_W) - 64'd1);
    localparam logic [MW-1:0] G_MAX = MW'((64'd1 << G_W) - 64'd1);
    localparam logic [MW-1:0] B_MAX = MW'((64'd1 << B_W) - 64'd1);

    // Channel values are held in MW bits but never exceed their own MAX,
    // so every result stays inside the channel's range.
    function automatic logic [MW-1:0] enh(
        input logic [MW-1:0]      c,
        input logic [MW-1:0]      mx,
        input logic [1:0]         md,
        input logic [SHIFT_W-1:0] sh
    );
        case (md)
            2'b00:   enh = c;
            2'b01:   enh = c + ((mx - c) >> sh);
            2'b10:   enh = c - (c >> sh);
            default: enh = mx - c;
        endcase
    endfunction

    logic               accept;
    logic               s2_load;
    logic               s1_valid;
    logic [PIX_W-1:0]   s1_pixel;
    logic               s1_sof;
    logic [1:0]         s1_mode;
    logic [SHIFT_W-1:0] s1_shift;
    logic [1:0]         cfg_mode;
    logic [SHIFT_W-1:0] cfg_shift;
    logic [23:0]        pix_cnt;
    logic               seen_sof;

    assign s2_load = !m_valid || m_ready;
    assign s_ready = !s1_valid || s2_load;
    assign accept  = s_valid && s_ready;

    // S1: capture the beat with the config it must use (live on SOF).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pixel <= '0;
            s1_sof   <= 1'b0;
            s1_mode  <= 2'b00;
            s1_shift <= '0;
        end else if (s_ready) begin
            s1_valid <= s_valid;
            if (s_valid) begin
                s1_pixel <= s_pixel;
                s1_sof   <= s_sof;
                s1_mode  <= s_sof ? mode : cfg_mode;
                s1_shift <= s_sof ? shift : cfg_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_mode  <= 2'b00;
            cfg_shift <= '0;
        end else if (accept && s_sof) begin
            cfg_mode  <= mode;
            cfg_shift <= shift;
        end
    end

    logic [MW-1:0]  r_full, g_full, b_full;
    logic [R_W-1:0] r_out;
    logic [G_W-1:0] g_out;
    logic [B_W-1:0] b_out;
    logic           unused_bits;

    assign r_full = enh(MW'(s1_pixel[PIX_W-1 -: R_W]), R_MAX, s1_mode, s1_shift);
    assign g_full = enh(MW'(s1_pixel[B_W +: G_W]), G_MAX, s1_mode, s1_shift);
    assign b_full = enh(MW'(s1_pixel[0 +: B_W]), B_MAX, s1_mode, s1_shift);

`ifdef PIXEL_ENH_FACE_TINT_EN
    logic s1_face;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_face <= 1'b0;
        end else if (accept) begin
            s1_face <= s_face;
        end
    end

    always_comb begin
        r_out = r_full[R_W-1:0];
        g_out = g_full[G_W-1:0];
        b_out = b_full[B_W-1:0];
        if (s1_face) begin
            r_out = '1;
            g_out = g_full[G_W-1:0] >> 1;
            b_out = b_full[B_W-1:0] >> 1;
        end
    end

    assign unused_bits = ^{r_full, g_full, b_full};
`else
    assign r_out = r_full[R_W-1:0];
    assign g_out = g_full[G_W-1:0];
    assign b_out = b_full[B_W-1:0];

    assign unused_bits = ^{r_full, g_full, b_full, s_face};
`endif

    // S2: output register, holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_pixel <= '0;
            m_sof   <= 1'b0;
        end else if (s2_load) begin
            m_valid <= s1_valid;
            if (s1_valid) begin
                m_pixel <= {r_out, g_out, b_out};
                m_sof   <= s1_sof;
            end
        end
    end

    // Statistics: the first SOF only opens a frame, it does not close one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt           <= '0;
            seen_sof          <= 1'b0;
            frame_count       <= '0;
            last_frame_pixels <= '0;
        end else if (accept) begin
            if (s_sof) begin
                if (seen_sof) begin
                    last_frame_pixels <= pix_cnt;
                end
                seen_sof    <= 1'b1;
                pix_cnt     <= 24'd1;
                frame_count <= frame_count + 16'd1;
            end else if (pix_cnt != 24'hFFFFFF) begin
                pix_cnt <= pix_cnt + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_enhance_pipe.sv
// tb_pixel_enhance_pipe: directed self-checking bench for pixel_enhance_pipe
// (RGB565 defaults): modes, config latch, face tint, backpressure, statistics, reset.

module tb_pixel_enhance_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_pixel;
    logic        s_valid;
    logic        s_ready;
    logic        s_sof;
    logic        s_face;
    logic [1:0]  mode;
    logic [2:0]  shift;
    logic [15:0] m_pixel;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic [15:0] frame_count;
    logic [23:0] last_frame_pixels;

    int errors = 0;
    int checks = 0;

    pixel_enhance_pipe dut (
        .clk               (clk),
        .rst               (rst),
        .s_pixel           (s_pixel),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_sof             (s_sof),
        .s_face            (s_face),
        .mode              (mode),
        .shift             (shift),
        .m_pixel           (m_pixel),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_sof             (m_sof),
        .frame_count       (frame_count),
        .last_frame_pixels (last_frame_pixels)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_face  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [15:0] pix, input logic sof,
                         input logic [1:0] md, input logic [2:0] sh,
                         input logic face);
        s_pixel = pix;
        s_sof   = sof;
        mode    = md;
        shift   = sh;
        s_face  = face;
        s_valid = 1'b1;
    endtask

    task automatic run_one(input string tag, input logic [15:0] pix,
                           input logic sof, input logic [1:0] md,
                           input logic [2:0] sh, input logic face,
                           input logic [15:0] exp);
        drive(pix, sof, md, sh, face);
        tick();
        s_valid = 1'b0;
        tick();
        chk(tag, {15'd0, m_valid, m_pixel}, {15'd0, 1'b1, exp});
        tick();
    endtask

    logic [15:0] pixv [8];
    logic [15:0] face_exp;

    initial begin
        int sent;
        int recv;
        bit dropped;

        m_ready = 1'b1;
        mode    = 2'b00;
        shift   = 3'd0;
        s_pixel = 16'h0000;
        do_reset();

        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_pixel", {16'd0, m_pixel}, 32'd0);
        chk("rst_m_sof", {31'd0, m_sof}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_last_frame", {8'd0, last_frame_pixels}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);

        drive(16'h8410, 1'b1, 2'b00, 3'd0, 1'b0);
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
        chk("lat_cycle1_valid", {31'd0, m_valid}, 32'd0);
        chk("lat_frame_count", {16'd0, frame_count}, 32'd1);
        tick();
        chk("lat_cycle2_valid", {31'd0, m_valid}, 32'd1);
        chk("lat_pixel", {16'd0, m_pixel}, 32'h8410);
        chk("lat_sof", {31'd0, m_sof}, 32'd1);
        tick();
        chk("lat_no_dup", {31'd0, m_valid}, 32'd0);

        run_one("mode_brighten", 16'h8410, 1'b1, 2'b01, 3'd1, 1'b0, 16'hBDF7);
        run_one("mode_darken", 16'h8410, 1'b1, 2'b10, 3'd1, 1'b0, 16'h4208);
        run_one("mode_invert", 16'h8410, 1'b1, 2'b11, 3'd1, 1'b0, 16'h7BEF);
        run_one("bright_shift0", 16'h8410, 1'b1, 2'b01, 3'd0, 1'b0, 16'hFFFF);
        run_one("darken_shift0", 16'h8410, 1'b1, 2'b10, 3'd0, 1'b0, 16'h0000);
        run_one("bright_shift7", 16'h8410, 1'b1, 2'b01, 3'd7, 1'b0, 16'h8410);

        drive(16'h8410, 1'b1, 2'b01, 3'd1, 1'b0);
        tick();
        drive(16'h8410, 1'b0, 2'b11, 3'd0, 1'b0);
        tick();
        s_valid = 1'b0;
        chk("latch_first", {15'd0, m_valid, m_pixel}, {15'd0, 1'b1, 16'hBDF7});
        tick();
        chk("latch_second", {15'd0, m_valid, m_pixel}, {15'd0, 1'b1, 16'hBDF7});
        tick();

`ifdef PIXEL_ENH_FACE_TINT_EN
        face_exp = 16'hFA08;
`else
        face_exp = 16'h8410;
`endif
        run_one("face_tint", 16'h8410, 1'b1, 2'b00, 3'd0, 1'b1, face_exp);

        for (int i = 0; i < 8; i++) begin
            pixv[i] = 16'h1111 * 16'(i + 1);
        end
        sent    = 0;
        recv    = 0;
        dropped = 1'b0;
        mode    = 2'b00;
        shift   = 3'd0;
        s_face  = 1'b0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            m_ready = (cyc < 4 || cyc >= 9);
            s_valid = (sent < 8);
            s_pixel = (sent < 8) ? pixv[sent] : 16'h0000;
            s_sof   = (sent == 0);
            #1;
            if (!s_ready && !dropped) begin
                dropped = 1'b1;
                chk("bp_held_at_drop", 32'(sent - recv), 32'd2);
            end
            if (m_valid && !m_ready) begin
                chk("bp_hold_stable", {16'd0, m_pixel}, {16'd0, pixv[recv]});
            end
            if (m_valid && m_ready) begin
                chk("bp_order", {16'd0, m_pixel}, {16'd0, pixv[recv]});
                recv++;
            end
            if (s_valid && s_ready) begin
                sent++;
            end
            tick();
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        chk("bp_saw_s_ready_low", {31'd0, dropped}, 32'd1);
        chk("bp_all_delivered", 32'(recv), 32'd8);
        tick();

        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(16'h0123, i == 0, 2'b00, 3'd0, 1'b0);
            tick();
        end
        chk("stat_first_frame", {8'd0, last_frame_pixels}, 32'd0);
        drive(16'h0123, 1'b1, 2'b00, 3'd0, 1'b0);
        tick();
        chk("stat_frame6", {8'd0, last_frame_pixels}, 32'd6);
        chk("stat_count2", {16'd0, frame_count}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            drive(16'h0123, 1'b0, 2'b00, 3'd0, 1'b0);
            tick();
        end
        drive(16'h0123, 1'b1, 2'b00, 3'd0, 1'b0);
        tick();
        chk("stat_frame4", {8'd0, last_frame_pixels}, 32'd4);
        chk("stat_count3", {16'd0, frame_count}, 32'd3);

        drive(16'h8410, 1'b1, 2'b11, 3'd0, 1'b0);
        tick();
        drive(16'h8410, 1'b0, 2'b11, 3'd0, 1'b0);
        tick();
        chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        rst     = 1'b1;
        s_valid = 1'b0;
        tick();
        chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_m_pixel", {16'd0, m_pixel}, 32'd0);
        chk("mid_rst_m_sof", {31'd0, m_sof}, 32'd0);
        chk("mid_rst_frames", {16'd0, frame_count}, 32'd0);
        chk("mid_rst_last", {8'd0, last_frame_pixels}, 32'd0);
        rst = 1'b0;
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        run_one("post_rst_bypass", 16'h8410, 1'b0, 2'b11, 3'd1, 1'b0, 16'h8410);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_enhance_pipe.md
# pixel_enhance_pipe

Parametrised, fully handshaked successor to the single-mode pixel enhancer in the image processing path. It accepts packed RGB pixels of configurable channel widths on a valid/ready stream. Each pixel passes through a two-stage pipeline that applies one of four per-frame enhancement modes, with an optional face-region tint. The block sits between the camera pixel stream plus face-detection flag and the display/output stage, and keeps per-frame statistics.

## Interface
- `R_W`, default 5: red channel width in bits.
- `G_W`, default 6: green channel width in bits.
- `B_W`, default 5: blue channel width in bits.
- `SHIFT_W`, default 3: width of the enhancement shift amount.
- `PIX_W` is derived as R_W+G_W+B_W. Packing is {R,G,B}, with R in the MSBs.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_pixel`  in  PIX_W  input pixel.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  block can accept a beat.
- `s_sof`  in  1  the beat is the first pixel of a frame.
- `s_face`  in  1  the pixel lies inside a detected face region.
- `mode`  in  2  enhancement mode: 00 bypass, 01 brighten, 10 darken, 11 invert.
- `shift`  in  SHIFT_W  enhancement strength.
- `m_pixel`  out  PIX_W  output pixel.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accepts.
- `m_sof`  out  1  `s_sof` delayed and aligned with `m_pixel`.
- `frame_count`  out  16  number of accepted SOF beats since reset; wraps at 16'hFFFF→0.
- `last_frame_pixels`  out  24  pixel count of the most recently completed frame.

## Operation
- A beat is accepted when `s_valid && s_ready`. A beat is delivered when `m_valid && m_ready`.
- **Config latching:** `mode` and `shift` are captured only on an accepted beat with `s_sof`=1.
  - The SOF beat itself uses the incoming values.
  - All later beats use the latched values until the next SOF.
  - After reset, before the first SOF, the latched values are mode=00, shift=0.
- **Per channel c, with MAX = 2^W−1 (W = channel width):**
  - Bypass: c.
  - Brighten: c + ((MAX−c) >> shift).
  - Darken: c − (c >> shift).
  - Invert: MAX − c.
- **Width rules:** intermediates are W bits; results never overflow or underflow.
  - shift ≥ W gives a zero shifted term.
  - Brighten with shift=0 gives MAX; darken with shift=0 gives 0.
- **Face tint** (see Configuration): applied after the mode result when `s_face`=1. R = MAX; G and B are each shifted right by 1.
- **Statistics:**
  - An internal 24-bit pixel counter increments on every accepted beat and saturates at 24'hFFFFFF.
  - On an accepted SOF beat:
    - `last_frame_pixels` ← counter value, only if at least one SOF has been seen before; otherwise it stays 0.
    - The counter reloads to 1.
    - `frame_count` increments.

## Timing
- **Pipeline:** two register stages, S1 (compute) and S2 (output). Latency is 2 cycles from acceptance to `m_valid` when `m_ready` is held at 1. Throughput is 1 beat/cycle.
- **Backpressure:**
  - S2 loads when it is empty or `m_ready`=1.
  - S1 advances when S2 can load.
  - `s_ready` = !S1_valid || S1_advance. This path is combinational from `m_ready`; there is no skid buffer.
- `m_pixel` and `m_sof` hold stable while `m_valid && !m_ready`. No beat is dropped or duplicated.
- **Simultaneous events:** acceptance in and delivery out can occur in the same cycle with a full pipeline. Throughput then stays at 1/cycle.
- **Reset values:** `m_valid`=0, `m_pixel`=0, `m_sof`=0, `frame_count`=0, `last_frame_pixels`=0, internal counter 0, and both stage valids 0.
  - `s_ready` is 1 in the first cycle after reset.
- **Reset mid-stream:** beats in flight are discarded and statistics are cleared. The latched config returns to bypass/shift 0.
- A SOF arriving while the previous frame is still in the pipeline is legal. The config latch affects only beats accepted from that SOF onward.

## Configuration
- `PIXEL_ENH_FACE_TINT_EN` defined: the face tint is applied to pixels with `s_face`=1, and `s_face` is pipelined alongside the pixel.
- Not defined: `s_face` is ignored, no face logic is synthesised, and the output is the mode result only.

## Test plan
All scenarios use default parameters (RGB565). Input pixel 16'h8410 is R=16, G=32, B=16.
- Reset, then one beat 16'h8410 with SOF, mode=00, face=0, `m_ready`=1 → 16'h8410 with `m_sof`=1, exactly 2 cycles later; `frame_count`=1.
- Mode=01, shift=1, SOF beat 16'h8410 → 16'hBDF7. Mode=10, shift=1 → 16'h4208. Mode=11 → 16'h7BEF. Each config change is presented on a SOF beat.
- Latch check: SOF beat with mode=01, shift=1, then a non-SOF beat with mode input changed to 11 → both outputs are 16'hBDF7.
- With `PIXEL_ENH_FACE_TINT_EN`: bypass, 16'h8410, `s_face`=1 → 16'hFA08. Without the macro → 16'h8410.
- Backpressure: stream 8 beats and hold `m_ready`=0 for 5 cycles mid-stream → `s_ready` drops after 2 beats are held, all 8 pixels emerge in order with no loss, and `m_pixel` is stable while stalled.
- Frames of 6 and then 4 pixels, followed by a third SOF → `last_frame_pixels` reads 6 after the second SOF and 4 after the third; `frame_count`=3. Asserting `rst` mid-frame → all outputs return to 0 on the next edge.
